// File: rtl/bitwise_logic_unit.sv
// ---------------------------------------------------------------------------
// bitwise_logic_unit
//
// Registered bitwise logic unit for the ALU / mult-div datapath. Each operand
// beat is combined as data1 OP data2 (AND, OR, XOR, ANDN), and the result can
// optionally be inverted (NAND, NOR, XNOR, ORN). In accumulate mode a stream of
// beats is folded into one result, for example an AND-mask or an XOR-parity.
// The result feeds the writeback mux.
//
// Parameters
//   WIDTH  operand/result width in bits (>= 1)
//   CNT_W  width of the saturating beat counter (>= 1)
//
// Ports
//   clock        rising-edge clock
//   reset        asynchronous active-high reset
//   in_valid     operand beat valid
//   in_ready     unit can accept a beat this cycle
//   data1/data2  operands A and B
//   op           00 AND, 01 OR, 10 XOR, 11 ANDN (data1 & ~data2)
//   inv          invert the final result
//   acc          beat belongs to an accumulate packet
//   last         final beat of an accumulate packet
//   out_valid    result valid
//   out_ready    downstream accepts the result
//   output_data  result
//   zero         output_data == 0
//   beat_count   beats folded into this result (saturating)
// ---------------------------------------------------------------------------
module bitwise_logic_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [1:0]       op,
  input  logic             inv,
  input  logic             acc,
  input  logic             last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] output_data,
  output logic             zero,
  output logic [CNT_W-1:0] beat_count
);

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_ANDN = 2'b11;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Per-beat operation.
  function automatic logic [WIDTH-1:0] beat_op(input logic [1:0]       o,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (o)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_ANDN: r = a & ~b;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Folds a beat into the accumulator. AND and ANDN both reduce as a mask,
  // so ANDN folds with AND.
  function automatic logic [WIDTH-1:0] fold_op(input logic [1:0]       o,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] r);
    logic [WIDTH-1:0] f;
    case (o)
      OP_OR:   f = a | r;
      OP_XOR:  f = a ^ r;
      default: f = a & r;
    endcase
    return f;
  endfunction

  // The beat counter saturates at all-ones. The accumulator keeps folding.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_ONE;
  endfunction

  // Packet state.
  logic             open_p1;
  logic [1:0]       op_lat_p1;
  logic             inv_lat_p1;
  logic             acc_lat_p1;
  logic [WIDTH-1:0] accum_p1;
  logic [CNT_W-1:0] cnt_p1;

  // Beat evaluation signals.
  logic             accept_p0;
  logic [1:0]       op_eff_p0;
  logic             inv_eff_p0;
  logic [WIDTH-1:0] beat_p0;
  logic [WIDTH-1:0] accum_nxt_p0;
  logic [CNT_W-1:0] cnt_nxt_p0;
  logic             complete_p0;
  logic [WIDTH-1:0] result_p0;

  // A held result blocks new beats. A result being taken this cycle frees the
  // slot, so in_ready depends combinationally on out_ready.
  assign in_ready = !out_valid || out_ready;

  // ---- stage p0: evaluate the incoming beat against the packet state ----
  always_comb begin
    accept_p0    = in_valid && in_ready;
    // After the first beat, the latched op/inv replace the live inputs.
    op_eff_p0    = open_p1 ? op_lat_p1 : op;
    inv_eff_p0   = open_p1 ? inv_lat_p1 : inv;
    beat_p0      = beat_op(op_eff_p0, data1, data2);
    accum_nxt_p0 = open_p1 ? fold_op(op_lat_p1, accum_p1, beat_p0) : beat_p0;
    cnt_nxt_p0   = open_p1 ? sat_inc(cnt_p1) : CNT_ONE;
    // A first beat closes at once unless it starts an accumulate packet
    // without last. An open packet always has acc latched, so for a
    // continuation beat only last matters.
    if (open_p1)
      complete_p0 = accept_p0 && (last || !acc_lat_p1);
    else
      complete_p0 = accept_p0 && (!acc || last);
    result_p0    = inv_eff_p0 ? ~accum_nxt_p0 : accum_nxt_p0;
  end

  // ---- stage p1: packet state and registered result ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      open_p1     <= 1'b0;
      op_lat_p1   <= OP_AND;
      inv_lat_p1  <= 1'b0;
      acc_lat_p1  <= 1'b0;
      accum_p1    <= '0;
      cnt_p1      <= '0;
      out_valid   <= 1'b0;
      output_data <= '0;
      zero        <= 1'b0;
      beat_count  <= '0;
    end else begin
      if (accept_p0) begin
        if (!open_p1) begin
          op_lat_p1  <= op;
          inv_lat_p1 <= inv;
          acc_lat_p1 <= acc;
        end
        accum_p1 <= accum_nxt_p0;
        cnt_p1   <= cnt_nxt_p0;
        open_p1  <= !complete_p0;
      end

      // A new completion replaces the old result, even when that result is
      // taken in the same cycle. Otherwise the result holds until taken.
      if (complete_p0) begin
        out_valid   <= 1'b1;
        output_data <= result_p0;
        zero        <= (result_p0 == '0);
        beat_count  <= cnt_nxt_p0;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bitwise_logic_unit.sv
module tb_bitwise_logic_unit;

  localparam int WIDTH = 32;
  localparam int CNT_W = 2;

  logic             clock;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] data2;
  logic [1:0]       op;
  logic             inv;
  logic             acc;
  logic             last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] output_data;
  logic             zero;
  logic [CNT_W-1:0] beat_count;

  bitwise_logic_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .data1       (data1),
    .data2       (data2),
    .op          (op),
    .inv         (inv),
    .acc         (acc),
    .last        (last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .output_data (output_data),
    .zero        (zero),
    .beat_count  (beat_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] data;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec;
  int   n_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, want, $time);
    end
  endtask

  // Scoreboard: pop one expected result on every output handshake.
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_out_valid", 32'(out_valid), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("output_data", output_data, e.data);
        check_eq("beat_count", 32'(beat_count), e.cnt);
        check_eq("zero", 32'(zero), (e.data == 32'd0) ? 32'd1 : 32'd0);
      end
    end
  end

  // Drives one beat and waits, with a bound, for it to be accepted. The
  // expected result is queued on the edge that accepts the completing beat.
  task automatic send_beat(input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] o, input logic i,
                           input logic ac, input logic la,
                           input bit push, input logic [31:0] ed,
                           input logic [31:0] ec);
    data1 = a; data2 = b; op = o; inv = i; acc = ac; last = la;
    in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clock);
      if (in_ready) begin
        if (push) begin
          exp_t e;
          e.data = ed;
          e.cnt  = ec;
          exp_q.push_back(e);
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    check_eq("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock); #1;
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [1:0] o, input logic [31:0] a,
                                         input logic [31:0] b, input logic i);
    logic [31:0] r;
    case (o)
      2'b00:   r = a & b;
      2'b01:   r = a | b;
      2'b10:   r = a ^ b;
      default: r = a & ~b;
    endcase
    return i ? ~r : r;
  endfunction

  initial begin
    n_vec = 0; n_err = 0;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    data1 = '0; data2 = '0; op = 2'b00; inv = 1'b0; acc = 1'b0; last = 1'b0;
    #12;
    // Reset state.
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_output_data", output_data, 32'd0);
    check_eq("rst_zero", 32'(zero), 32'd0);
    check_eq("rst_beat_count", 32'(beat_count), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clock); #1;
    reset = 1'b0;
    idle(1);

    // Single beats on consecutive cycles.
    send_beat(32'hF0F0F0F0, 32'hFF00FF00, 2'b00, 1'b0, 1'b0, 1'b0, 1, 32'hF000F000, 1);
    check_eq("latency_single", 32'(out_valid), 32'd1);
    send_beat(32'hF0F0F0F0, 32'hFF00FF00, 2'b01, 1'b0, 1'b0, 1'b0, 1, 32'hFFF0FFF0, 1);
    send_beat(32'hF0F0F0F0, 32'hFF00FF00, 2'b10, 1'b0, 1'b0, 1'b0, 1, 32'h0FF00FF0, 1);
    send_beat(32'hF0F0F0F0, 32'hFF00FF00, 2'b11, 1'b0, 1'b0, 1'b0, 1, 32'h00F000F0, 1);
    send_beat(32'hF0F0F0F0, 32'hFF00FF00, 2'b00, 1'b1, 1'b0, 1'b0, 1, 32'h0FFF0FFF, 1);
    idle(2);

    // XOR parity over three beats.
    send_beat(32'd1, 32'd0, 2'b10, 1'b0, 1'b1, 1'b0, 0, 32'd0, 0);
    send_beat(32'd2, 32'd0, 2'b10, 1'b0, 1'b1, 1'b0, 0, 32'd0, 0);
    check_eq("parity_no_early_valid", 32'(out_valid), 32'd0);
    send_beat(32'd4, 32'd1, 2'b10, 1'b0, 1'b1, 1'b1, 1, 32'h00000006, 3);
    check_eq("parity_latency", 32'(out_valid), 32'd1);
    idle(2);

    // Backpressure: hold a result, in_ready must drop and data must hold.
    out_ready = 1'b0;
    send_beat(32'hF0F0F0F0, 32'hFF00FF00, 2'b00, 1'b0, 1'b0, 1'b0, 1, 32'hF000F000, 1);
    data1 = 32'hF0F0F0F0; data2 = 32'hFF00FF00; op = 2'b10; inv = 1'b0;
    acc = 1'b0; last = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check_eq("bp_in_ready", 32'(in_ready), 32'd0);
      check_eq("bp_out_valid", 32'(out_valid), 32'd1);
      check_eq("bp_data_hold", output_data, 32'hF000F000);
      check_eq("bp_count_hold", 32'(beat_count), 32'd1);
    end
    @(posedge clock); #1;
    out_ready = 1'b1;
    send_beat(32'hF0F0F0F0, 32'hFF00FF00, 2'b10, 1'b0, 1'b0, 1'b0, 1, 32'h0FF00FF0, 1);
    send_beat(32'h12345678, 32'h0000FFFF, 2'b01, 1'b1, 1'b0, 1'b0, 1, 32'hEDCB0000, 1);
    idle(2);

    // Op latching: a continuation beat's op is ignored.
    send_beat(32'h0000FFFF, 32'h0000FF0F, 2'b00, 1'b0, 1'b1, 1'b0, 0, 32'd0, 0);
    send_beat(32'h00000FFF, 32'h0000FFFF, 2'b01, 1'b1, 1'b0, 1'b1, 1, 32'h00000F0F, 2);
    idle(2);

    // Zero flag.
    send_beat(32'h1, 32'h1, 2'b11, 1'b0, 1'b0, 1'b0, 1, 32'h00000000, 1);
    idle(1);

    // Counter saturation (CNT_W=2): five beats still give exact data.
    for (int k = 0; k < 5; k++) begin
      if (k == 4)
        send_beat(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 1'b0, 1'b1, 1'b1, 1, 32'hFFFFFFFF, 3);
      else
        send_beat(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 1'b0, 1'b1, 1'b0, 0, 32'd0, 0);
    end
    idle(2);

    // Reset in the middle of an open packet.
    send_beat(32'hFFFFFFFF, 32'h0F0F0F0F, 2'b00, 1'b0, 1'b1, 1'b0, 0, 32'd0, 0);
    send_beat(32'hFFFFFFFF, 32'h00FF00FF, 2'b00, 1'b0, 1'b1, 1'b0, 0, 32'd0, 0);
    #2;
    reset = 1'b1;
    #1;
    exp_q.delete();
    check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_output_data", output_data, 32'd0);
    check_eq("midrst_beat_count", 32'(beat_count), 32'd0);
    check_eq("midrst_zero", 32'(zero), 32'd0);
    check_eq("midrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clock); #3;
    reset = 1'b0;
    @(posedge clock); #1;
    send_beat(32'd5, 32'd3, 2'b10, 1'b0, 1'b0, 1'b0, 1, 32'h00000006, 1);
    idle(2);

    // Random single beats, back-to-back.
    for (int k = 0; k < 16; k++) begin
      logic [31:0] a, b;
      logic [1:0]  o;
      logic        i;
      a = $urandom; b = $urandom;
      o = 2'($urandom_range(0, 3));
      i = 1'($urandom_range(0, 1));
      send_beat(a, b, o, i, 1'b0, 1'($urandom_range(0, 1)), 1, ref_op(o, a, b, i), 1);
    end
    idle(3);

    check_eq("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bitwise_logic_unit.md
# bitwise_logic_unit

Parametrised, registered bitwise logic unit for the ALU/mult-div datapath. It applies one of four bitwise operations, with optional inversion, to two WIDTH-bit operands under a valid/ready handshake. In accumulate mode it reduces a multi-beat stream into one result, for example the AND-mask or XOR-parity of N operand pairs. It feeds the writeback mux alongside the multiplier/divider result path.

## Interface
- WIDTH, 32, operand/result width in bits (>=1)
- CNT_W, 8, width of beat counter (>=1)

- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  unit can accept a beat this cycle
- data1  input  WIDTH  operand A
- data2  input  WIDTH  operand B
- op  input  2  00 AND, 01 OR, 10 XOR, 11 ANDN (data1 & ~data2)
- inv  input  1  invert final result (NAND/NOR/XNOR/ORN)
- acc  input  1  1 = beat belongs to an accumulate packet
- last  input  1  final beat of accumulate packet (ignored when acc=0 on first beat)
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- output_data  output  WIDTH  result
- zero  output  1  output_data == 0
- beat_count  output  CNT_W  beats folded into this result, saturating

## Operation
- Beat accepted when in_valid && in_ready. in_ready = !out_valid || out_ready, combinational from registered out_valid and from out_ready.
- Per-beat value: r = data1 OP data2 (OP from op).
- Packet state: flag open, registered op_l, inv_l, acc_l, accumulator A[WIDTH], counter C[CNT_W].
- First beat (open=0): op, inv, and acc are sampled into op_l, inv_l, acc_l. A <= r. C <= 1.
  - If acc=0, or acc=1 && last=1: the packet completes on this beat.
  - Otherwise open <= 1.
- Continuation beat (open=1): op, inv, and acc inputs are ignored; op_l applies. A <= A COMB r, where COMB is AND for op_l in {AND, ANDN}, OR for OR, and XOR for XOR. C <= C+1, saturating at 2^CNT_W-1. If last=1, the packet completes and open <= 0.
- Completion: output_data <= inv_l ? ~final : final, where final is the updated A value. beat_count <= final C. zero <= (output_data value == 0). out_valid <= 1.
- Continuation beats with last=0 produce no output. They are still gated by in_ready.
- out_valid clears on out_ready when no new completion occurs in the same cycle. Simultaneous handshake plus completion: out_valid stays 1 and the new result replaces the old one.
- output_data, zero, and beat_count hold stable while out_valid && !out_ready.

## Timing
- Reset (asynchronous, any cycle): out_valid=0, output_data=0, zero=0, beat_count=0, open=0, A=0, C=0. A packet in progress is discarded. in_ready=1 after reset.
- Latency: result is visible the cycle after the completing beat is accepted.
- Throughput: 1 beat/cycle sustained while out_ready=1.
- Backpressure: with out_valid=1 and out_ready=0, in_ready=0. No beats are accepted and no state changes.
- Counter saturation: beat_count stays at 2^CNT_W-1 for longer packets. The accumulator result remains exact.

## Test plan
- Single beats, WIDTH=32, acc=0: (0xF0F0F0F0, 0xFF00FF00) with op AND, OR, XOR, ANDN, then AND+inv -> 0xF000F000, 0xFFF0FFF0, 0x0FF00FF0, 0x00F000F0, 0x0FFF0FFF on consecutive cycles, each with beat_count=1 and zero=0.
- Accumulate XOR parity: 3 beats, op=XOR, acc=1, pairs (1,0), (2,0), (4,1), last on beat 3 -> one output 0x00000006, beat_count=3. No out_valid before the cycle after beat 3.
- Backpressure: out_ready=0 after the first result, in_valid held -> in_ready=0 and output_data stable for 5 cycles. Then out_ready=1 -> the next result is accepted back-to-back.
- Op latching: packet started with op=AND, continuation beat drives op=OR -> result uses AND. AND (0xFFFF,0xFF0F) then (0x0FFF,0xFFFF) -> 0x00000F0F.
- Saturation, CNT_W=2: 5-beat AND packet of all-ones -> beat_count=3, output 0xFFFFFFFF. ANDN(0x1,0x1) single beat -> zero=1.
- Reset mid-packet: assert reset after 2 beats of an open packet -> outputs zero immediately. A new single beat, XOR (5,3), -> 0x00000006, beat_count=1, with no stale accumulator.
